spike_isi_encoder: RTL

- Downstream consumer of the neuron core's spike output.
- Detects spike events and measures inter-spike intervals (ISI) in clock cycles.
- Buffers ISIs in a first-word-fall-through FIFO with a valid/ready output.
- Publishes a per-window spike count for rate coding.

---
 rtl/spike_isi_encoder_if.sv | 26 ++
 rtl/spike_isi_encoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spike_isi_encoder_if.sv
// Output bundle of spike_isi_encoder: ISI stream with valid/ready handshake,
// FIFO status and the windowed spike-rate result.
interface spike_isi_encoder_if #(
    parameter int unsigned ISI_W = 12,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    logic [ISI_W-1:0] isi_data;
    logic             isi_valid;
    logic             isi_ready;
    logic [LvlW-1:0]  fifo_level;
    logic             overflow;
    logic [7:0]       rate_count;
    logic             rate_valid;

    modport master (
        output isi_data, isi_valid, fifo_level, overflow, rate_count, rate_valid,
        input  isi_ready
    );

    modport slave (
        input  isi_data, isi_valid, fifo_level, overflow, rate_count, rate_valid,
        output isi_ready
    );
endinterface

// File: rtl/spike_isi_encoder.sv
// Spike edge detector feeding an inter-spike-interval FIFO and a windowed rate counter.
// Define REFRACTORY_EN to ignore rises for REFRACT cycles after each accepted event.
module spike_isi_encoder #(
    parameter int unsigned ISI_W   = 12,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WIN_LEN = 256,
    parameter int unsigned REFRACT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          spike_in,
    spike_isi_encoder_if.master isi_bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned WinW = $clog2(WIN_LEN);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIN_LEN < 2 || ISI_W < 2 ||
        REFRACT > 65535) begin : g_bad_params
        $error("spike_isi_encoder: unsupported parameter set");
    end

    logic             act, rise, evt;
    logic             prev_act_q, armed_q;
    logic [ISI_W-1:0] isi_cnt_q;

    assign act  = |spike_in;
    assign rise = act & ~prev_act_q;

`ifdef REFRACTORY_EN
    localparam int unsigned RefW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    logic [RefW-1:0] refr_q;

    assign evt = rise & (refr_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refr_q <= '0;
        end else if (evt) begin
            refr_q <= RefW'(REFRACT);
        end else if (refr_q != '0) begin
            refr_q <= refr_q - RefW'(1);
        end
    end
`else
    assign evt = rise;
`endif

    // Interval counter restarts at 1 so its value at the next event equals the gap in cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_act_q <= 1'b0;
            armed_q    <= 1'b0;
            isi_cnt_q  <= '0;
        end else begin
            prev_act_q <= act;
            if (evt) begin
                armed_q   <= 1'b1;
                isi_cnt_q <= ISI_W'(1);
            end else if (isi_cnt_q != '1) begin
                isi_cnt_q <= isi_cnt_q + ISI_W'(1);
            end
        end
    end

    // ISI FIFO
    logic [ISI_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q, level_d;
    logic             overflow_q;
    logic             push, pop, full, valid, wr_en;

    assign valid = (level_q != '0);
    assign full  = (level_q == LvlW'(DEPTH));
    assign push  = evt & armed_q;
    assign pop   = valid & isi_bus.isi_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= isi_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Rate window
    logic [WinW-1:0] win_q;
    logic [7:0]      ev_cnt_q, ev_cnt_inc, rate_count_q;
    logic            rate_valid_q, win_end;

    assign win_end    = (win_q == WinW'(WIN_LEN - 1));
    assign ev_cnt_inc = (evt && ev_cnt_q != 8'hff) ? ev_cnt_q + 8'd1 : ev_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q        <= '0;
            ev_cnt_q     <= '0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            win_q        <= win_end ? '0 : win_q + WinW'(1);
            rate_valid_q <= win_end;
            if (win_end) begin
                rate_count_q <= ev_cnt_inc;
                ev_cnt_q     <= '0;
            end else begin
                ev_cnt_q <= ev_cnt_inc;
            end
        end
    end

    assign isi_bus.isi_data   = valid ? mem_q[rd_ptr_q] : '0;
    assign isi_bus.isi_valid  = valid;
    assign isi_bus.fifo_level = level_q;
    assign isi_bus.overflow   = overflow_q;
    assign isi_bus.rate_count = rate_count_q;
    assign isi_bus.rate_valid = rate_valid_q;
endmodule
